// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit path.
package serial_pkg;

  localparam int unsigned SERIAL_WORD_W = 32;

  // Drain controller states for serial_tx_queue.
  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone
  } tx_queue_state_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// Register-array storage for a word FIFO: one write port, one combinational read port.
// The data array carries no reset; validity is tracked by the owner's pointers.
module sync_fifo_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: store the word at the write address.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/serial_tx_queue.sv
// Word FIFO plus drain controller feeding the serial_tx trigger/ready handshake.
// Optional feature: define SERIAL_TX_QUEUE_DROP_COUNT_EN to add a saturating
// drop_count_out port counting pushes discarded while the queue is full.
module serial_tx_queue
  import serial_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_WORD_W,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_in,
  input  logic                     push_in,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     flush_in,
  output logic                     full_out,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     busy_out,
  input  logic                     tx_ready_in,
  output logic                     tx_trigger_out,
  output logic [WIDTH-1:0]         tx_data_out
`ifdef SERIAL_TX_QUEUE_DROP_COUNT_EN
  ,
  output logic [15:0]              drop_count_out
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  tx_queue_state_t state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] tx_data_q;
  logic [WIDTH-1:0] rd_data;
  logic             full;
  logic             pop;
  logic             push_ok;

  assign full = (count_q == CW'(DEPTH));
  // A pop only happens when leaving IDLE; flush blocks it so nothing is issued mid-clear.
  assign pop = (state_q == StIdle) && (count_q != '0) && tx_ready_in && !flush_in;
  // A pop frees a slot in the same cycle, so a full queue can still accept.
  assign push_ok = push_in && (!full || pop) && !flush_in;

  sync_fifo_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (push_ok),
    .wr_addr(wr_ptr_q),
    .wr_data(data_in),
    .rd_addr(rd_ptr_q),
    .rd_data(rd_data)
  );

  // Next pointer and occupancy values; flush clears queued words only.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Drain controller next state: issue one trigger, then track ready low then high.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (pop) state_d = StIssue;
      StIssue:    state_d = StWaitBusy;
      StWaitBusy: if (!tx_ready_in) state_d = StWaitDone;
      StWaitDone: if (tx_ready_in) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Drain controller state register.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Outgoing word is captured at the pop and held until the next pop.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      tx_data_q <= '0;
    end else if (pop) begin
      tx_data_q <= rd_data;
    end
  end

  assign tx_trigger_out = (state_q == StIssue);
  assign busy_out       = (state_q != StIdle);
  assign full_out       = full;
  assign count_out      = count_q;
  assign tx_data_out    = tx_data_q;

`ifdef SERIAL_TX_QUEUE_DROP_COUNT_EN
  logic        drop;
  logic [15:0] drop_q;

  assign drop = push_in && full && !pop;

  // Saturating count of discarded pushes; survives flush, cleared only by reset.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count_out = drop_q;
`endif

endmodule
